// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker: sweeps A/B over all four vectors, checks De Morgan identities on the observed gate outputs (DMCHK_GOLDEN_EN adds golden-value checks)
module demorgan_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ITERATIONS = 1,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             obs_nanb,
  input  logic             obs_nab,
  input  logic             obs_nanorb,
  input  logic             obs_naorb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} stateT;
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_ITER = 8'(ITERATIONS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  stateT state, stateNext;
  logic [3:0] cnt, cntNext;
  logic [1:0] vec, vecNext;
  logic [7:0] iter, iterNext;
  logic drvANext, drvBNext, passR, passNext, vecFail, lastVec;
  logic [ERR_W-1:0] errNext;
  logic [3:0] failNext;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign pass = passR;
  assign lastVec = vec == 2'd3 && iter == LAST_ITER;
`ifdef DMCHK_GOLDEN_EN
  assign vecFail = (obs_nanb != obs_naorb) || (obs_nab != obs_nanorb) ||
                   (obs_nanb != (~drv_a & ~drv_b)) || (obs_nab != ~(drv_a & drv_b)) ||
                   (obs_nanorb != (~drv_a | ~drv_b)) || (obs_naorb != ~(drv_a | drv_b));
`else
  assign vecFail = (obs_nanb != obs_naorb) || (obs_nab != obs_nanorb);
`endif
  // next-state and datapath updates; every register holds unless its state says otherwise
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    vecNext = vec;
    iterNext = iter;
    drvANext = drv_a;
    drvBNext = drv_b;
    errNext = err_count;
    failNext = fail_vec;
    passNext = passR;
    case (state)
      IDLE: if (start) begin
        stateNext = SETTLE;
        cntNext = RELOAD;
        vecNext = 2'd0;
        iterNext = 8'd0;
        drvANext = 1'b0;
        drvBNext = 1'b0;
        errNext = '0;
        failNext = 4'd0;
        passNext = 1'b0;
      end
      SETTLE: begin
        cntNext = cnt == 4'd0 ? cnt : cnt - 4'd1;
        stateNext = cnt == 4'd0 ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        errNext = vecFail && err_count != ERR_MAX ? err_count + 1'b1 : err_count;
        failNext = fail_vec | (vecFail ? 4'b0001 << vec : 4'd0);
        vecNext = vec + 2'd1;
        iterNext = vec == 2'd3 ? iter + 8'd1 : iter;
        drvANext = lastVec ? drv_a : vecNext[1];
        drvBNext = lastVec ? drv_b : vecNext[0];
        cntNext = RELOAD;
        passNext = lastVec ? errNext == '0 : passR;
        stateNext = lastVec ? DONE : SETTLE;
      end
      default: stateNext = IDLE;
    endcase
  end
  // state and datapath registers with asynchronous abort to reset values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      vec <= 2'd0;
      iter <= 8'd0;
      drv_a <= 1'b0;
      drv_b <= 1'b0;
      err_count <= '0;
      fail_vec <= 4'd0;
      passR <= 1'b0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      vec <= vecNext;
      iter <= iterNext;
      drv_a <= drvANext;
      drv_b <= drvBNext;
      err_count <= errNext;
      fail_vec <= failNext;
      passR <= passNext;
    end
  end
endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// tb_demorgan_sweep_checker: drives two checker instances against fault-injectable gate models
module tb_demorgan_sweep_checker;
  logic clk = 0, rst_n = 0;
  logic startA = 0, startB = 0;
  logic aA, bA, aB, bB, busyA, doneA, passA, busyB, doneB, passB;
  logic [3:0] oA, oB, errA, errB, fvA, fvB;
  logic [7:0] fA = 0, fB = 0;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;

  // fault code per gate output: 0 healthy, 1 stuck-0, 2 stuck-1, 3 inverted
  function automatic logic ap(input logic [1:0] c, input logic g);
    return c == 2'd0 ? g : c == 2'd1 ? 1'b0 : c == 2'd2 ? 1'b1 : ~g;
  endfunction

  function automatic logic [3:0] gates(input logic [7:0] f, input logic a, input logic b);
    return {ap(f[7:6], ~a & ~b), ap(f[5:4], ~(a & b)), ap(f[3:2], ~a | ~b), ap(f[1:0], ~(a | b))};
  endfunction

  assign oA = gates(fA, aA, bA);
  assign oB = gates(fB, aB, bB);

  demorgan_sweep_checker dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .drv_a(aA), .drv_b(bA),
    .obs_nanb(oA[3]), .obs_nab(oA[2]), .obs_nanorb(oA[1]), .obs_naorb(oA[0]),
    .busy(busyA), .done(doneA), .pass(passA), .err_count(errA), .fail_vec(fvA)
  );

  demorgan_sweep_checker #(.SETTLE_CYCLES(1), .ITERATIONS(20), .ERR_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .drv_a(aB), .drv_b(bB),
    .obs_nanb(oB[3]), .obs_nab(oB[2]), .obs_nanorb(oB[1]), .obs_naorb(oB[0]),
    .busy(busyB), .done(doneB), .pass(passB), .err_count(errB), .fail_vec(fvB)
  );

  function automatic void predict(input logic [7:0] f, input int iters, output int err,
                                  output logic [3:0] fv, output logic ps);
    int n = 0;
    fv = 4'd0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv;
      logic [3:0] o, g;
      bit bad;
      vv = 2'(v);
      g = gates(8'h00, vv[1], vv[0]);
      o = gates(f, vv[1], vv[0]);
      bad = (o[3] != o[0]) || (o[2] != o[1]);
`ifdef DMCHK_GOLDEN_EN
      bad = bad || (o != g);
`endif
      if (bad) begin
        fv[v] = 1'b1;
        n++;
      end
    end
    err = n * iters > 15 ? 15 : n * iters;
    ps = err == 0;
  endfunction

  task automatic runDut(input int d, input logic [7:0] f, output int lat);
    @(negedge clk);
    if (d == 1) begin fB = f; startB = 1; end else begin fA = f; startA = 1; end
    @(negedge clk);
    startA = 0;
    startB = 0;
    lat = 1;
    while (!(d == 1 ? doneB : doneA) && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    compared++;
    if ({aA, bA, busyA, doneA, passA, errA, fvA} !== 13'd0) begin
      mismatched++;
      $display("FAIL reset_a got %b want 0", {aA, bA, busyA, doneA, passA, errA, fvA});
    end
    compared++;
    if ({aB, bB, busyB, doneB, passB, errB, fvB} !== 13'd0) begin
      mismatched++;
      $display("FAIL reset_b got %b want 0", {aB, bB, busyB, doneB, passB, errB, fvB});
    end
  endtask

  task automatic test_clean;
    int lat;
    runDut(0, 8'h00, lat);
    compared++;
    if (lat !== 13) begin mismatched++; $display("FAIL t1_latency got %0d want 13", lat); end
    compared++;
    if ({passA, errA, fvA} !== 9'b1_0000_0000) begin
      mismatched++;
      $display("FAIL t1_result got pass=%b err=%0d fv=%b want 1/0/0000", passA, errA, fvA);
    end
    @(negedge clk);
    compared++;
    if ({busyA, doneA, passA, aA, bA} !== 5'b00111) begin
      mismatched++;
      $display("FAIL t1_idle got %b want 00111", {busyA, doneA, passA, aA, bA});
    end
  endtask

  task automatic test_stuck;
    int lat;
    runDut(0, 8'b00_00_00_01, lat);
    compared++;
    if ({passA, errA, fvA} !== 9'b0_0001_0001) begin
      mismatched++;
      $display("FAIL t2_result got pass=%b err=%0d fv=%b want 0/1/0001", passA, errA, fvA);
    end
  endtask

  task automatic test_saturate;
    int lat;
    runDut(1, 8'b00_11_00_00, lat);
    compared++;
    if (lat !== 161) begin mismatched++; $display("FAIL t3_latency got %0d want 161", lat); end
    compared++;
    if ({passB, errB, fvB} !== 9'b0_1111_1111) begin
      mismatched++;
      $display("FAIL t3_result got pass=%b err=%0d fv=%b want 0/15/1111", passB, errB, fvB);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    fA = 8'h00;
    startA = 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!doneA && lat < 400);
    compared++;
    if (lat !== 13) begin mismatched++; $display("FAIL t4_latency got %0d want 13", lat); end
    @(negedge clk);
    compared++;
    if ({busyA, doneA} !== 2'b00) begin
      mismatched++;
      $display("FAIL t4_after_done got busy/done=%b want 00", {busyA, doneA});
    end
    lat = 0;
    do begin
      @(negedge clk);
      startA = 0;
      lat++;
    end while (!doneA && lat < 400);
    compared++;
    if (lat !== 13 || passA !== 1'b1) begin
      mismatched++;
      $display("FAIL t4_second_run got lat=%0d pass=%b want 13/1", lat, passA);
    end
  endtask

  task automatic test_abort;
    int lat, dones;
    @(negedge clk);
    fA = 8'b00_00_00_01;
    startA = 1;
    @(negedge clk);
    startA = 0;
    repeat (7) @(negedge clk);
    compared++;
    if ({busyA, aA, bA} !== 3'b110) begin
      mismatched++;
      $display("FAIL t5_in_vec2 got busy/a/b=%b want 110", {busyA, aA, bA});
    end
    rst_n = 0;
    #1;
    compared++;
    if ({aA, bA, busyA, doneA, passA, errA, fvA} !== 13'd0) begin
      mismatched++;
      $display("FAIL t5_abort got %b want 0", {aA, bA, busyA, doneA, passA, errA, fvA});
    end
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (doneA) dones++;
    end
    rst_n = 1;
    repeat (20) begin
      @(negedge clk);
      if (doneA) dones++;
    end
    compared++;
    if (dones !== 0) begin mismatched++; $display("FAIL t5_no_done got %0d want 0", dones); end
    runDut(0, 8'h00, lat);
    compared++;
    if (lat !== 13 || {passA, errA, fvA} !== 9'b1_0000_0000) begin
      mismatched++;
      $display("FAIL t5_rerun got lat=%0d pass=%b err=%0d fv=%b want 13/1/0/0000", lat, passA, errA, fvA);
    end
  endtask

  task automatic test_golden;
    int lat;
    logic [8:0] want;
`ifdef DMCHK_GOLDEN_EN
    want = 9'b0_0011_1110;
`else
    want = 9'b1_0000_0000;
`endif
    runDut(0, 8'b10_00_00_10, lat);
    compared++;
    if ({passA, errA, fvA} !== want) begin
      mismatched++;
      $display("FAIL t6_result got %b want %b", {passA, errA, fvA}, want);
    end
  endtask

  task automatic test_random;
    int lat, err, d, iters, settle;
    logic [7:0] f;
    logic [3:0] fv;
    logic ps;
    for (int k = 0; k < 12; k++) begin
      d = k % 2;
      iters = d == 1 ? 20 : 1;
      settle = d == 1 ? 1 : 2;
      f = 8'($urandom);
      if ($urandom_range(0, 3) == 0) f = 8'h00;
      predict(f, iters, err, fv, ps);
      runDut(d, f, lat);
      compared++;
      if (lat !== 4 * iters * (settle + 1) + 1) begin
        mismatched++;
        $display("FAIL rand_latency dut=%0d got %0d want %0d", d, lat, 4 * iters * (settle + 1) + 1);
      end
      compared++;
      if (d == 1 ? {passB, errB, fvB} !== {ps, 4'(err), fv} : {passA, errA, fvA} !== {ps, 4'(err), fv}) begin
        mismatched++;
        $display("FAIL rand_result dut=%0d f=%h got %b want %b", d, f,
                 d == 1 ? {passB, errB, fvB} : {passA, errA, fvA}, {ps, 4'(err), fv});
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1;
    @(negedge clk);
    test_clean;
    test_stuck;
    test_saturate;
    test_back_to_back;
    test_abort;
    test_golden;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
